// File: rtl/water_level_encoder.sv
// Water-level probe encoder: synchronise, debounce and thermometer-decode three probes into a 2-bit level code.
// Optional build macro WATER_LEVEL_STEP_LIMIT_EN limits each commit to a single level step.
module water_level_encoder #(
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       probe_low,
   input  logic       probe_mid,
   input  logic       probe_high,
   output logic [1:0] data,
   output logic       level_valid,
   output logic       fault,
   output logic       changed
);

   localparam int              CW     = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   N_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [2:0]    r_sync1;
   logic [2:0]    r_sync2;
   logic [2:0]    r_cand;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_data;
   logic          r_valid;
   logic          r_fault;
   logic          r_changed;

   logic          w_commit;
   logic          w_pat_ok;
   logic [1:0]    w_target;
   logic [1:0]    w_next_data;
   logic          w_restart;

   assign w_commit = (r_sync2 == r_cand) && (r_cnt == N_LAST);

   always_comb begin
      w_pat_ok = 1'b1;
      w_target = r_data;
      case (r_cand)
         3'b000:  w_target = 2'b00;
         3'b001:  w_target = 2'b01;
         3'b011:  w_target = 2'b10;
         3'b111:  w_target = 2'b11;
         default: w_pat_ok = 1'b0;
      endcase
   end

`ifdef WATER_LEVEL_STEP_LIMIT_EN
   // Move one level per commit; re-arm the full debounce period until the target is reached.
   always_comb begin
      w_next_data = r_data;
      if (w_target > r_data)
         w_next_data = r_data + 2'd1;
      else if (w_target < r_data)
         w_next_data = r_data - 2'd1;
   end
   assign w_restart = w_commit && w_pat_ok && (w_next_data != w_target);
`else
   assign w_next_data = w_target;
   assign w_restart   = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 3'b000;
         r_sync2 <= 3'b000;
      end else begin
         r_sync1 <= {probe_high, probe_mid, probe_low};
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cand <= 3'b000;
         r_cnt  <= '0;
      end else if (r_sync2 != r_cand) begin
         r_cand <= r_sync2;
         r_cnt  <= '0;
      end else if (r_cnt != N_LAST) begin
         r_cnt  <= r_cnt + 1'b1;
      end else if (w_restart) begin
         r_cnt  <= '0;
      end
   end

   // Saturated counter re-commits every cycle; changed only fires when something visible moves.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data    <= 2'b00;
         r_valid   <= 1'b0;
         r_fault   <= 1'b0;
         r_changed <= 1'b0;
      end else begin
         r_changed <= 1'b0;
         if (w_commit) begin
            if (w_pat_ok) begin
               r_data    <= w_next_data;
               r_valid   <= 1'b1;
               r_fault   <= 1'b0;
               r_changed <= (w_next_data != r_data) || !r_valid;
            end else begin
               r_fault   <= 1'b1;
            end
         end
      end
   end

   assign data        = r_data;
   assign level_valid = r_valid;
   assign fault       = r_fault;
   assign changed     = r_changed;

endmodule

// File: tb/tb_water_level_encoder.sv
// Scoreboard bench for water_level_encoder with DEBOUNCE_CYCLES = 4.
// Expectations follow WATER_LEVEL_STEP_LIMIT_EN when it is defined.
module tb_water_level_encoder;

   logic       clk;
   logic       reset_n;
   logic       probe_low;
   logic       probe_mid;
   logic       probe_high;
   logic [1:0] data;
   logic       level_valid;
   logic       fault;
   logic       changed;

   typedef struct {
      int         cyc;
      logic [1:0] d;
      logic       v;
      logic       f;
      logic       ch;
   } exp_t;

   exp_t q[$];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   int   cur_d = 0;
   logic prev_f = 1'b0;

   water_level_encoder #(.DEBOUNCE_CYCLES(4)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .probe_low   (probe_low),
      .probe_mid   (probe_mid),
      .probe_high  (probe_high),
      .data        (data),
      .level_valid (level_valid),
      .fault       (fault),
      .changed     (changed)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   // Monitor: every changed pulse or fault transition must match the next queued expectation.
   always @(negedge clk) begin
      if (reset_n) begin
         if (changed || (fault != prev_f)) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL event: unexpected at cycle %0d data=%b valid=%b fault=%b changed=%b",
                        cyc, data, level_valid, fault, changed);
            end else begin
               exp_t e;
               e = q.pop_front();
               if (e.cyc != cyc || e.d != data || e.v != level_valid || e.f != fault || e.ch != changed) begin
                  bad++;
                  $display("FAIL event: got cyc=%0d d=%b v=%b f=%b ch=%b, want cyc=%0d d=%b v=%b f=%b ch=%b",
                           cyc, data, level_valid, fault, changed, e.cyc, e.d, e.v, e.f, e.ch);
               end
            end
         end
         prev_f = fault;
      end else begin
         prev_f = 1'b0;
      end
   end

   task automatic push(input int c, input logic [1:0] d, input logic v, input logic f, input logic ch);
      exp_t e;
      e.cyc = c; e.d = d; e.v = v; e.f = f; e.ch = ch;
      q.push_back(e);
   endtask

   task automatic step_push(input int base, input int to);
`ifdef WATER_LEVEL_STEP_LIMIT_EN
      int d = cur_d;
      int c = base + 7;
      while (d != to) begin
         d = (to > d) ? d + 1 : d - 1;
         push(c, 2'(d), 1'b1, 1'b0, 1'b1);
         c += 4;
      end
`else
      push(base + 7, 2'(to), 1'b1, 1'b0, 1'b1);
`endif
      cur_d = to;
   endtask

   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] p, output int base);
      @(negedge clk);
      {probe_high, probe_mid, probe_low} = p;
      base = cyc;
   endtask

   initial begin
      int base;
      reset_n = 1'b0;
      {probe_high, probe_mid, probe_low} = 3'b000;
      #3;
      chk("reset_outputs", {data, level_valid, fault}, 4'b0000);
      chk("reset_changed", {3'b000, changed}, 4'b0000);
      repeat (2) @(negedge clk);

      // First commit of the all-dry pattern at edge 4 after release.
      reset_n = 1'b1;
      base = cyc;
      push(base + 4, 2'b00, 1'b1, 1'b0, 1'b1);
      cur_d = 0;
      repeat (3) @(negedge clk);
      chk("pre_commit_valid", {3'b000, level_valid}, 4'b0000);
      repeat (5) @(negedge clk);
      chk("t1_state", {data, level_valid, fault}, {2'b00, 1'b1, 1'b0});

      drive(3'b011, base);
      step_push(base, 2);
      repeat (20) @(negedge clk);
      chk("t2_data", {2'b00, data}, 4'd2);

      // Two-cycle glitch on the high probe must not reach the outputs.
      drive(3'b111, base);
      repeat (2) @(negedge clk);
      probe_high = 1'b0;
      repeat (12) @(negedge clk);
      chk("glitch_data", {data, level_valid, fault}, {2'b10, 1'b1, 1'b0});

      drive(3'b101, base);
      push(base + 7, 2'b10, 1'b1, 1'b1, 1'b0);
      repeat (12) @(negedge clk);
      chk("fault_hold", {data, level_valid, fault}, {2'b10, 1'b1, 1'b1});

      drive(3'b111, base);
      step_push(base, 3);
      repeat (20) @(negedge clk);
      chk("fault_clear", {data, level_valid, fault}, {2'b11, 1'b1, 1'b0});

      drive(3'b000, base);
      step_push(base, 0);
      repeat (20) @(negedge clk);
      chk("down_to_00", {data, level_valid, fault}, {2'b00, 1'b1, 1'b0});

      // Reset mid-debounce of a pending 000 -> 111 change.
      drive(3'b111, base);
      repeat (4) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_reset_outputs", {data, level_valid, fault}, 4'b0000);
      chk("mid_reset_changed", {3'b000, changed}, 4'b0000);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      base = cyc;
      cur_d = 0;
      step_push(base, 3);
      repeat (6) @(negedge clk);
      chk("post_reset_hold", {data, level_valid, fault}, 4'b0000);
      repeat (14) @(negedge clk);
      chk("post_reset_final", {data, level_valid, fault}, {2'b11, 1'b1, 1'b0});

      drive(3'b001, base);
      step_push(base, 1);
      repeat (20) @(negedge clk);
      chk("to_low", {data, level_valid, fault}, {2'b01, 1'b1, 1'b0});

      drive(3'b010, base);
      push(base + 7, 2'b01, 1'b1, 1'b1, 1'b0);
      repeat (12) @(negedge clk);
      chk("fault_010", {data, level_valid, fault}, {2'b01, 1'b1, 1'b1});

      #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL pending: got %0d unseen events want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
